// File: rtl/mem_stage_memwb_pkg.sv
// Shared definitions for the MEM stage / MEM-WB register slice.
// Contents:
//   - access size encodings used by Store_size_in / Load_size_in
//   - MEM/WB field widths and the packed MEM/WB register record
//   - alignment helper shared by the store and load paths
package mem_stage_memwb_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int BE_W   = WORD_W / 8;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              misaligned;
    logic [WORD_W-1:0] rdata;
    logic [WORD_W-1:0] alu;
    logic [REG_W-1:0]  dest;
  } memwb_t;

  // Reserved size counts as aligned; it is suppressed separately so that it
  // never raises the misaligned flag.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_WORD: return (lane == 2'b00);
      SZ_HALF: return !lane[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_memwb_data_mem.sv
// Word-organised data memory with per-byte write enables.
// Ports:
//   Clk    in  rising-edge clock
//   we     in  write strobe (already qualified by the caller)
//   be     in  byte lane enables, bit 0 = bits 7:0
//   index  in  word index
//   wdata  in  write data (lane-replicated by the caller)
//   rdata  out combinational read of the addressed word (pre-write value)
module data_mem_be
  import mem_stage_memwb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter     INIT_FILE  = ""
) (
  input  logic                  Clk,
  input  logic                  we,
  input  logic [BE_W-1:0]       be,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge Clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) r_mem[index][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = r_mem[index];

endmodule

// File: rtl/mem_stage_memwb.sv
// MEM pipeline stage plus the MEM/WB register.
// Ports:
//   Clk, Reset (sync, active-high), Stall, Flush       control
//   MemWrite_in, MemRead_in, Branch_in, MemtoReg_in,
//   RegWrite_in, Zero_in                               EX/MEM control bits
//   ALUAddResult_in  branch target; ALUResult_in byte address / ALU result
//   WriteData_in store data; DestReg_in destination register
//   Store_size_in / Load_size_in  00 word, 01 half, 10 byte, 11 reserved
//   PCSrc_out, BranchTarget_out   combinational branch resolution
//   *_MEMWB                       registered write-back operands
module mem_stage_memwb
  import mem_stage_memwb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter     INIT_FILE  = ""
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              Branch_in,
  input  logic              MemtoReg_in,
  input  logic              RegWrite_in,
  input  logic [WORD_W-1:0] ALUAddResult_in,
  input  logic              Zero_in,
  input  logic [WORD_W-1:0] ALUResult_in,
  input  logic [WORD_W-1:0] WriteData_in,
  input  logic [REG_W-1:0]  DestReg_in,
  input  logic [1:0]        Store_size_in,
  input  logic [1:0]        Load_size_in,
  output logic              PCSrc_out,
  output logic [WORD_W-1:0] BranchTarget_out,
  output logic              RegWrite_out_MEMWB,
  output logic              MemtoReg_out_MEMWB,
  output logic [WORD_W-1:0] ReadData_out_MEMWB,
  output logic [WORD_W-1:0] ALUResult_out_MEMWB,
  output logic [REG_W-1:0]  DestReg_out_MEMWB,
  output logic              Misaligned_out_MEMWB
);

  function automatic logic [BE_W-1:0] store_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_WORD: return 4'b1111;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: return 4'b0001 << lane;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the low byte/half across the word so the byte enables alone
  // pick the destination lane.
  function automatic logic [WORD_W-1:0] store_data(input logic [1:0] size, input logic [WORD_W-1:0] wd);
    case (size)
      SZ_HALF: return {2{wd[15:0]}};
      SZ_BYTE: return {4{wd[7:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] load_extract(input logic [1:0] size, input logic [1:0] lane,
                                                     input logic [WORD_W-1:0] word);
    logic signed [15:0] h;
    logic signed [7:0]  b;
    h = lane[1] ? word[31:16] : word[15:0];
    b = word[{lane, 3'b000} +: 8];
    case (size)
      SZ_WORD: return word;
      SZ_HALF: return WORD_W'(h);
      SZ_BYTE: return WORD_W'(b);
      default: return '0;
    endcase
  endfunction

  logic [1:0]            w_lane;
  logic [DEPTH_LOG2-1:0] w_index;
  logic                  w_st_ok;
  logic                  w_ld_ok;
  logic                  w_misaligned;
  logic                  w_we;
  logic [WORD_W-1:0]     w_mem_rdata;
  logic [WORD_W-1:0]     w_load;
  memwb_t                w_next;
  memwb_t                r_memwb;

  assign w_lane  = ALUResult_in[1:0];
  assign w_index = ALUResult_in[DEPTH_LOG2+1:2];

  assign w_st_ok      = is_aligned(Store_size_in, w_lane) && (Store_size_in != SZ_RSVD);
  assign w_ld_ok      = is_aligned(Load_size_in, w_lane) && (Load_size_in != SZ_RSVD);
  assign w_misaligned = (MemRead_in  && !is_aligned(Load_size_in, w_lane)) ||
                        (MemWrite_in && !is_aligned(Store_size_in, w_lane));
  assign w_we         = MemWrite_in && !Stall && !Reset && w_st_ok;

  data_mem_be #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) u_dmem (
    .Clk   (Clk),
    .we    (w_we),
    .be    (store_be(Store_size_in, w_lane)),
    .index (w_index),
    .wdata (store_data(Store_size_in, WriteData_in)),
    .rdata (w_mem_rdata)
  );

  // The memory read is of the pre-store word, so a simultaneous load and
  // store returns the old contents.
  assign w_load = (MemRead_in && w_ld_ok) ? load_extract(Load_size_in, w_lane, w_mem_rdata) : '0;

  assign PCSrc_out        = Branch_in & Zero_in;
  assign BranchTarget_out = ALUAddResult_in;

  always_comb begin
    w_next            = '0;
    w_next.regwrite   = RegWrite_in;
    w_next.memtoreg   = MemtoReg_in;
    w_next.misaligned = w_misaligned;
    w_next.rdata      = w_load;
    w_next.alu        = ALUResult_in;
    w_next.dest       = DestReg_in;
  end

  // MEM/WB register boundary
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_memwb <= '0;
    end else if (Flush) begin
      r_memwb <= '0;
    end else if (!Stall) begin
      r_memwb <= w_next;
    end
  end

  assign RegWrite_out_MEMWB   = r_memwb.regwrite;
  assign MemtoReg_out_MEMWB   = r_memwb.memtoreg;
  assign Misaligned_out_MEMWB = r_memwb.misaligned;
  assign ReadData_out_MEMWB   = r_memwb.rdata;
  assign ALUResult_out_MEMWB  = r_memwb.alu;
  assign DestReg_out_MEMWB    = r_memwb.dest;

endmodule

// File: tb/tb_mem_stage_memwb.sv
module tb_mem_stage_memwb;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        MemWrite_in = 1'b0;
  logic        MemRead_in = 1'b0;
  logic        Branch_in = 1'b0;
  logic        MemtoReg_in = 1'b0;
  logic        RegWrite_in = 1'b0;
  logic [31:0] ALUAddResult_in = '0;
  logic        Zero_in = 1'b0;
  logic [31:0] ALUResult_in = '0;
  logic [31:0] WriteData_in = '0;
  logic [4:0]  DestReg_in = '0;
  logic [1:0]  Store_size_in = '0;
  logic [1:0]  Load_size_in = '0;
  logic        PCSrc_out;
  logic [31:0] BranchTarget_out;
  logic        RegWrite_out_MEMWB;
  logic        MemtoReg_out_MEMWB;
  logic [31:0] ReadData_out_MEMWB;
  logic [31:0] ALUResult_out_MEMWB;
  logic [4:0]  DestReg_out_MEMWB;
  logic        Misaligned_out_MEMWB;

  mem_stage_memwb #(.DEPTH_LOG2(8), .INIT_FILE("")) dut (
    .Clk                  (Clk),
    .Reset                (Reset),
    .Stall                (Stall),
    .Flush                (Flush),
    .MemWrite_in          (MemWrite_in),
    .MemRead_in           (MemRead_in),
    .Branch_in            (Branch_in),
    .MemtoReg_in          (MemtoReg_in),
    .RegWrite_in          (RegWrite_in),
    .ALUAddResult_in      (ALUAddResult_in),
    .Zero_in              (Zero_in),
    .ALUResult_in         (ALUResult_in),
    .WriteData_in         (WriteData_in),
    .DestReg_in           (DestReg_in),
    .Store_size_in        (Store_size_in),
    .Load_size_in         (Load_size_in),
    .PCSrc_out            (PCSrc_out),
    .BranchTarget_out     (BranchTarget_out),
    .RegWrite_out_MEMWB   (RegWrite_out_MEMWB),
    .MemtoReg_out_MEMWB   (MemtoReg_out_MEMWB),
    .ReadData_out_MEMWB   (ReadData_out_MEMWB),
    .ALUResult_out_MEMWB  (ALUResult_out_MEMWB),
    .DestReg_out_MEMWB    (DestReg_out_MEMWB),
    .Misaligned_out_MEMWB (Misaligned_out_MEMWB)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic        mis;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  dest;
  } wb_fields_t;

  typedef struct {
    int         due;
    string      nm;
    wb_fields_t f;
  } wb_exp_t;

  typedef struct {
    int          due;
    string       nm;
    logic        pc;
    logic [31:0] tgt;
  } br_exp_t;

  wb_exp_t    q_wb[$];
  br_exp_t    q_br[$];
  wb_fields_t prev_f = '0;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic       br_b = 1'b0;
  logic       br_z = 1'b0;
  logic [31:0] br_t = '0;

  localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: pops an expectation when its cycle comes up and compares.
  always @(negedge Clk) begin
    wb_exp_t    e;
    br_exp_t    b;
    wb_fields_t act;
    if (q_wb.size() > 0 && q_wb[0].due <= cyc) begin
      e = q_wb.pop_front();
      act = {RegWrite_out_MEMWB, MemtoReg_out_MEMWB, Misaligned_out_MEMWB,
             ReadData_out_MEMWB, ALUResult_out_MEMWB, DestReg_out_MEMWB};
      n_tests++;
      if (e.due != cyc || act !== e.f) begin
        n_fail++;
        $display("FAIL %s: got rw=%b mtr=%b mis=%b rd=%h alu=%h dest=%0d, want rw=%b mtr=%b mis=%b rd=%h alu=%h dest=%0d",
                 e.nm, act.rw, act.mtr, act.mis, act.rd, act.alu, act.dest,
                 e.f.rw, e.f.mtr, e.f.mis, e.f.rd, e.f.alu, e.f.dest);
      end
    end
    if (q_br.size() > 0 && q_br[0].due <= cyc) begin
      b = q_br.pop_front();
      n_tests++;
      if (b.due != cyc || PCSrc_out !== b.pc || BranchTarget_out !== b.tgt) begin
        n_fail++;
        $display("FAIL %s: got pcsrc=%b target=%h, want pcsrc=%b target=%h",
                 b.nm, PCSrc_out, BranchTarget_out, b.pc, b.tgt);
      end
    end
  end

  task automatic step(input logic rst, input logic stall, input logic flush,
                      input logic mr, input logic mw, input logic [1:0] ss, input logic [1:0] ls,
                      input logic [31:0] alu, input logic [31:0] wd,
                      input logic rw, input logic mtr, input logic [4:0] dest,
                      input logic [31:0] exp_rd, input logic exp_mis, input string nm);
    wb_exp_t e;
    @(posedge Clk); #1;
    Reset = rst; Stall = stall; Flush = flush;
    MemRead_in = mr; MemWrite_in = mw; Store_size_in = ss; Load_size_in = ls;
    ALUResult_in = alu; WriteData_in = wd;
    RegWrite_in = rw; MemtoReg_in = mtr; DestReg_in = dest;
    Branch_in = br_b; Zero_in = br_z; ALUAddResult_in = br_t;
    if (rst || flush)  e.f = '0;
    else if (stall)    e.f = prev_f;
    else               e.f = {rw, mtr, exp_mis, exp_rd, alu, dest};
    prev_f = e.f;
    e.due = cyc + 1;
    e.nm  = nm;
    q_wb.push_back(e);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic mis, input string nm);
    step(0, 0, 0, 0, 1, W, W, a, d, 0, 0, 0, 32'h0, mis, nm);
  endtask

  task automatic ld(input logic [1:0] ls, input logic [31:0] a, input logic [31:0] exp,
                    input logic mis, input string nm);
    step(0, 0, 0, 1, 0, W, ls, a, 32'h0, 1, 1, 5'd5, exp, mis, nm);
  endtask

  task automatic br_step(input logic b, input logic z, input logic [31:0] t,
                         input logic exp_pc, input string nm);
    br_exp_t x;
    br_b = b; br_z = z; br_t = t;
    step(0, 0, 0, 0, 0, W, W, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, {nm, "_wb"});
    x.due = cyc; x.nm = nm; x.pc = exp_pc; x.tgt = t;
    q_br.push_back(x);
  endtask

  initial begin
    // Reset with live inputs: register must stay cleared.
    step(1, 0, 0, 0, 0, W, W, 32'h1234, 32'h0, 1, 0, 5'd3, 32'h0, 0, "reset_c1");
    step(1, 0, 0, 0, 0, W, W, 32'h1234, 32'h0, 1, 0, 5'd3, 32'h0, 0, "reset_c2");
    step(0, 0, 0, 0, 0, W, W, 32'h1234, 32'h0, 1, 0, 5'd3, 32'h0, 0, "alu_pass");

    // Word store then word/half/byte loads with sign extension.
    sw(32'h10, 32'hDEADBEEF, 0, "sw_10");
    ld(W, 32'h10, 32'hDEADBEEF, 0, "lw_10");
    ld(H, 32'h12, 32'hFFFFDEAD, 0, "lh_12");
    ld(B, 32'h13, 32'hFFFFFFDE, 0, "lb_13");
    ld(B, 32'h10, 32'hFFFFFFEF, 0, "lb_10");

    // Sub-word stores into a cleared word.
    sw(32'h10, 32'h0, 0, "sw_10_clr");
    step(0, 0, 0, 0, 1, B, W, 32'h11, 32'h0000007F, 0, 0, 0, 32'h0, 0, "sb_11");
    ld(W, 32'h10, 32'h00007F00, 0, "lw_10_after_sb");
    sw(32'h14, 32'h0, 0, "sw_14_clr");
    step(0, 0, 0, 0, 1, H, W, 32'h16, 32'h00008001, 0, 0, 0, 32'h0, 0, "sh_16");
    ld(W, 32'h14, 32'h80010000, 0, "lw_14_after_sh");

    // Misaligned accesses.
    sw(32'h20, 32'h11223344, 0, "sw_20");
    sw(32'h22, 32'hCAFEF00D, 1, "sw_22_misaligned");
    ld(W, 32'h20, 32'h11223344, 0, "lw_20_unchanged");
    ld(H, 32'h21, 32'h0, 1, "lh_21_misaligned");

    // Stall holds outputs and blocks the store; Flush clears even with Stall.
    sw(32'h30, 32'h0, 0, "sw_30_clr");
    step(0, 0, 0, 1, 0, W, W, 32'h30, 32'h0, 1, 1, 5'd7, 32'h0, 0, "lw_30_pre");
    step(0, 1, 0, 0, 1, W, W, 32'h30, 32'h55, 1, 0, 5'd9, 32'h0, 0, "stall_hold");
    ld(W, 32'h30, 32'h0, 0, "lw_30_after_stall");
    step(0, 1, 1, 0, 1, W, W, 32'h30, 32'h66, 1, 0, 5'd9, 32'h0, 0, "flush_stall");
    ld(W, 32'h30, 32'h0, 0, "lw_30_after_flush_stall");
    step(0, 0, 1, 0, 1, W, W, 32'h34, 32'h77, 1, 0, 5'd9, 32'h0, 0, "flush_store");
    ld(W, 32'h34, 32'h77, 0, "lw_34_after_flush");

    // Branch resolution is combinational.
    br_step(1, 1, 32'h400, 1, "branch_taken");
    br_step(1, 0, 32'h400, 0, "branch_not_taken");
    br_b = 0; br_z = 0; br_t = '0;

    // Address wrap: 0x400 aliases word 0 for DEPTH_LOG2=8.
    sw(32'h400, 32'hA5A55A5A, 0, "sw_400");
    ld(W, 32'h000, 32'hA5A55A5A, 0, "lw_000_wrap");

    // Simultaneous load and store returns the pre-store word.
    sw(32'h40, 32'h12345678, 0, "sw_40");
    step(0, 0, 0, 1, 1, W, W, 32'h40, 32'h9ABCDEF0, 1, 1, 5'd6, 32'h12345678, 0, "lw_sw_40");
    ld(W, 32'h40, 32'h9ABCDEF0, 0, "lw_40_after");

    step(0, 0, 0, 0, 0, W, W, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, "idle");
    repeat (3) @(posedge Clk);
    #1;
    if (q_wb.size() != 0 || q_br.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q_wb.size() + q_br.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion by 100000, want completion");
    $fatal(1, "timeout");
  end

endmodule
